// File: rtl/pulseox_pkg.sv
// Shared pulse-oximeter time-domain constants and the sample-buffer FSM encoding.
// Used by td_sample_buffer and td_sort.
package pulseox_pkg;

    localparam int unsigned DATA_W          = 22;
    localparam int unsigned DEPTH           = 1503;
    localparam int unsigned ADDR_W          = 11;
    localparam int unsigned UPDATE_INTERVAL = 250;
    localparam int unsigned CNT_W           = 12;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_IDLE  = 2'd3
    } td_buf_state_e;

endpackage

// File: rtl/td_sample_ram.sv
// Simple dual-port sample RAM: write port A, registered read port B.
// A same-address read and write return the old word; out-of-range reads return 0.
module td_sample_ram #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned DEPTH  = 1503,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W-1:0] NumWords = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (raddr_i < NumWords) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/td_sample_buffer.sv
// Circular LED1 sample store feeding the time-domain sorter; paces sort requests.
// Optional dropped-interval counter enabled by defining TD_BUF_OVERRUN_CNT_EN.
module td_sample_buffer #(
    parameter int unsigned DATA_W          = pulseox_pkg::DATA_W,
    parameter int unsigned DEPTH           = pulseox_pkg::DEPTH,
    parameter int unsigned ADDR_W          = pulseox_pkg::ADDR_W,
    parameter int unsigned UPDATE_INTERVAL = pulseox_pkg::UPDATE_INTERVAL
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_dv,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] q_b,
    input  logic              sort_done,
    output logic              sort_dv,
    output logic [11:0]       new_cnt,
    output logic              buf_full
`ifdef TD_BUF_OVERRUN_CNT_EN
    ,
    output logic [15:0]       overrun_cnt
`endif
);

    import pulseox_pkg::*;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [11:0]       FillLast = 12'(DEPTH - 1);
    localparam logic [11:0]       IvlLen   = 12'(UPDATE_INTERVAL);

    td_buf_state_e     state_q;
    logic [ADDR_W-1:0] wr_ptr_q, last_wr_q;
    logic [11:0]       fill_cnt_q, ivl_cnt_q;
    logic              pending_q, sort_dv_q, buf_full_q;
    logic [11:0]       new_cnt_q;

    logic [11:0]       ivl_inc;
    logic              ivl_hit;
    logic [ADDR_W-1:0] newest;

    always_comb begin
        ivl_inc = ivl_cnt_q + {11'b0, sample_dv};
        ivl_hit = sample_dv && (ivl_inc == IvlLen);
        // The sample written this cycle is the newest one a request can name.
        newest  = sample_dv ? wr_ptr_q : last_wr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            last_wr_q <= '0;
        end else if (sample_dv) begin
            last_wr_q <= wr_ptr_q;
            wr_ptr_q  <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FILL;
            fill_cnt_q <= '0;
            ivl_cnt_q  <= '0;
            pending_q  <= 1'b0;
            sort_dv_q  <= 1'b0;
            new_cnt_q  <= '0;
            buf_full_q <= 1'b0;
        end else begin
            sort_dv_q <= 1'b0;
            unique case (state_q)
                S_FILL: begin
                    if (sample_dv) begin
                        fill_cnt_q <= fill_cnt_q + 12'd1;
                        if (fill_cnt_q == FillLast) begin
                            buf_full_q <= 1'b1;
                            state_q    <= S_ISSUE;
                            sort_dv_q  <= 1'b1;
                            new_cnt_q  <= 12'(newest);
                        end
                    end
                end
                S_ISSUE: begin
                    // A sample landing here already belongs to the next interval.
                    ivl_cnt_q <= {11'b0, sample_dv};
                    pending_q <= 1'b0;
                    state_q   <= S_BUSY;
                end
                S_BUSY: begin
                    if (ivl_hit) begin
                        ivl_cnt_q <= '0;
                        pending_q <= 1'b1;
                    end else begin
                        ivl_cnt_q <= ivl_inc;
                    end
                    if (sort_done) begin
                        if (pending_q || ivl_hit) begin
                            state_q   <= S_ISSUE;
                            sort_dv_q <= 1'b1;
                            new_cnt_q <= 12'(newest);
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    ivl_cnt_q <= ivl_inc;
                    if (ivl_hit) begin
                        state_q   <= S_ISSUE;
                        sort_dv_q <= 1'b1;
                        new_cnt_q <= 12'(newest);
                    end
                end
            endcase
        end
    end

`ifdef TD_BUF_OVERRUN_CNT_EN
    logic [15:0] overrun_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_q <= '0;
        end else if ((state_q == S_BUSY) && ivl_hit && pending_q && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign overrun_cnt = overrun_q;
`endif

    td_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (sample_dv),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_in),
        .raddr_i (addr_b),
        .rdata_o (q_b)
    );

    assign sort_dv  = sort_dv_q;
    assign new_cnt  = new_cnt_q;
    assign buf_full = buf_full_q;

endmodule

// File: tb/tb_td_sample_buffer.sv
// Directed bench for td_sample_buffer: per-cycle comparison against a behavioural
// model of the buffer and request pacing, plus hand-computed spot checks.
module tb_td_sample_buffer;

    localparam int D  = 1503;
    localparam int UI = 250;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [21:0] sample_in;
    logic        sample_dv;
    logic [10:0] addr_b;
    logic [21:0] q_b;
    logic        sort_done;
    logic        sort_dv;
    logic [11:0] new_cnt;
    logic        buf_full;
`ifdef TD_BUF_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    always #5 clk = ~clk;

    td_sample_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_in (sample_in),
        .sample_dv (sample_dv),
        .addr_b    (addr_b),
        .q_b       (q_b),
        .sort_done (sort_done),
        .sort_dv   (sort_dv),
        .new_cnt   (new_cnt),
        .buf_full  (buf_full)
`ifdef TD_BUF_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int dv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sample history plus request bookkeeping.
    logic [21:0] m_mem [D];
    bit          m_val [D];
    int          m_wr, m_last, m_filled, m_since, m_drops;
    bit          m_full, m_busy, m_owed, m_issue, m_ready = 0;
    bit          issue;
    int          newest;
    bit          exp_dv, exp_q_chk;
    int          exp_new;
    logic [21:0] exp_q;

    always @(posedge clk) begin
        if (addr_b >= 11'(D)) begin
            exp_q = '0;
            exp_q_chk = 1;
        end else begin
            exp_q = m_mem[addr_b];
            exp_q_chk = m_val[addr_b];
        end
        if (!reset_n) begin
            for (int i = 0; i < D; i++) m_val[i] = 0;
            m_wr = 0; m_last = 0; m_filled = 0; m_since = 0; m_drops = 0;
            m_full = 0; m_busy = 0; m_owed = 0; m_issue = 0;
            exp_dv = 0; exp_new = 0; exp_q = '0; exp_q_chk = 1;
            m_ready = 1;
        end else begin
            issue = 0;
            newest = m_last;
            if (sample_dv) begin
                m_mem[m_wr] = sample_in;
                m_val[m_wr] = 1;
                newest = m_wr;
                m_last = m_wr;
                m_wr = (m_wr + 1) % D;
                if (!m_full) begin
                    m_filled++;
                    if (m_filled == D) begin
                        m_full = 1;
                        issue = 1;
                    end
                end else begin
                    m_since++;
                    if (m_since % UI == 0) begin
                        if (!m_busy) issue = 1;
                        else if (m_owed) m_drops++;
                        else m_owed = 1;
                    end
                end
            end
            if (sort_done && m_busy && !m_issue) begin
                if (m_owed) issue = 1;
                else m_busy = 0;
            end
            m_issue = issue;
            exp_dv = issue;
            if (issue) begin
                exp_new = newest;
                m_busy = 1;
                m_owed = 0;
                m_since = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("sort_dv", 32'(sort_dv), 32'(exp_dv));
            chk("new_cnt", 32'(new_cnt), 32'(exp_new));
            chk("buf_full", 32'(buf_full), 32'(m_full));
            if (exp_q_chk) chk("q_b", 32'(q_b), 32'(exp_q));
            if (sort_dv === 1'b1) dv_count++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [21:0] v);
        sample_in = v;
        sample_dv = 1'b1;
        cyc();
        sample_dv = 1'b0;
    endtask

    task automatic pulse_done();
        sort_done = 1'b1;
        cyc();
        sort_done = 1'b0;
    endtask

    int dv0;

    initial begin
        reset_n = 1'b0; sample_in = '0; sample_dv = 1'b0; addr_b = '0; sort_done = 1'b0;
        cyc(); cyc();
        chk("rst sort_dv", 32'(sort_dv), 0);
        chk("rst buf_full", 32'(buf_full), 0);
        chk("rst new_cnt", 32'(new_cnt), 0);
        chk("rst q_b", 32'(q_b), 0);
        reset_n = 1'b1;
        cyc();

        // Fill with value = index; first request one cycle after the last fill write.
        dv0 = dv_count;
        for (int i = 0; i < D; i++) put(22'(i));
        chk("fill sort_dv", 32'(sort_dv), 1);
        chk("fill new_cnt", 32'(new_cnt), 1502);
        chk("fill buf_full", 32'(buf_full), 1);
        cyc();
        chk("fill pulse width", 32'(sort_dv), 0);
        chk("fill dv count", 32'(dv_count - dv0), 1);

        // Read back the whole store, then an out-of-range address.
        for (int a = 0; a < D; a++) begin
            addr_b = 11'(a);
            cyc();
            chk("readback", 32'(q_b), 32'(a));
        end
        addr_b = 11'd1600;
        cyc();
        chk("read oob", 32'(q_b), 0);
        addr_b = '0;

        // One interval while busy, then sort_done releases it.
        dv0 = dv_count;
        for (int i = 0; i < UI; i++) put(22'h200000 | 22'(i));
        cyc();
        chk("ivl no early dv", 32'(dv_count - dv0), 0);
        pulse_done();
        chk("ivl sort_dv", 32'(sort_dv), 1);
        chk("ivl new_cnt", 32'(new_cnt), 249);
        cyc();

        // Busy for 600 samples: second interval dropped, one request.
        dv0 = dv_count;
        for (int i = 0; i < 600; i++) put(22'h3FF000 + 22'(i));
        cyc();
        pulse_done();
        chk("ovr sort_dv", 32'(sort_dv), 1);
        chk("ovr new_cnt", 32'(new_cnt), 849);
        cyc();
        chk("ovr dv count", 32'(dv_count - dv0), 1);
        chk("ovr model drops", 32'(m_drops), 1);
`ifdef TD_BUF_OVERRUN_CNT_EN
        chk("overrun_cnt", 32'(overrun_cnt), 1);
`endif

        // No pending: sort_done idles; the 250th sample then issues directly.
        pulse_done();
        dv0 = dv_count;
        for (int i = 0; i < UI; i++) put(22'(i * 3));
        chk("idle sort_dv", 32'(sort_dv), 1);
        chk("idle new_cnt", 32'(new_cnt), 1099);
        cyc();
        chk("idle dv count", 32'(dv_count - dv0), 1);

        // The 250th sample coincides with sort_done.
        for (int i = 0; i < UI - 1; i++) put(22'(i));
        sort_done = 1'b1;
        put(22'h155555);
        sort_done = 1'b0;
        chk("same-cycle sort_dv", 32'(sort_dv), 1);
        chk("same-cycle new_cnt", 32'(new_cnt), 1349);
        cyc();

        // Read the address being written, across the 1502->0 wrap.
        for (int i = 0; i < 300; i++) begin
            addr_b = 11'((1350 + i) % D);
            put(22'h0AAAAA ^ 22'(i));
            if (i == 152) chk("collision 1502 old", 32'(q_b), 1502);
            if (i == 153) chk("collision 0 old", 32'(q_b), 32'h200000);
        end
        addr_b = '0;
        cyc();
        pulse_done();
        chk("wrap sort_dv", 32'(sort_dv), 1);
        chk("wrap new_cnt", 32'(new_cnt), 146);
        cyc();

        // Reset mid-busy; a sort_done just after reset is ignored.
        for (int i = 0; i < 10; i++) put(22'(i));
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("rerst buf_full", 32'(buf_full), 0);
        chk("rerst new_cnt", 32'(new_cnt), 0);
        dv0 = dv_count;
        pulse_done();
        for (int i = 0; i < D - 1; i++) put(22'(D - i));
        cyc();
        chk("refill no dv", 32'(dv_count - dv0), 0);
        put(22'h3FFFFF);
        chk("refill sort_dv", 32'(sort_dv), 1);
        chk("refill new_cnt", 32'(new_cnt), 1502);
        chk("refill buf_full", 32'(buf_full), 1);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
